// File: rtl/discrete_pkg.sv
// Shared types and the RC step arithmetic for the discrete-circuit audio blocks.
package discrete_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned DIFF_W   = SAMPLE_W + 1;
  localparam int unsigned PROD_W   = 2 * DIFF_W;
  localparam int unsigned STEP_W   = SAMPLE_W + 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_CHARGE,
    ENV_HOLD,
    ENV_DISCHARGE
  } env_state_t;

  // One exponential RC step from cur toward tgt; a nonzero gap always moves by at least 1 LSB
  // so the target is reached exactly, and the step never exceeds the gap.
  function automatic sample_t rc_step(sample_t cur, sample_t tgt, logic [COEF_W-1:0] coef);
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [STEP_W-1:0] step;
    logic signed [STEP_W-1:0] sum;
    diff = DIFF_W'(tgt) - DIFF_W'(cur);
    prod = PROD_W'(diff) * $signed(PROD_W'(coef));
    step = STEP_W'(prod >>> FRAC_W);
    if ((diff != '0) && (step == '0)) begin
      step = diff[DIFF_W-1] ? -STEP_W'(1) : STEP_W'(1);
    end
    sum = STEP_W'(cur) + step;
    return SAMPLE_W'(sum);
  endfunction

endpackage

// File: rtl/rc_envelope_cv_if.sv
// Trigger/strobe in, control voltage and busy out, between a sequencer and the envelope.
interface rc_envelope_cv_if;
  import discrete_pkg::*;

  logic    audio_clk_en;
  logic    trigger;
  sample_t out;
  logic    busy;

  modport master (
    output audio_clk_en,
    output trigger,
    input  out,
    input  busy
  );

  modport slave (
    input  audio_clk_en,
    input  trigger,
    output out,
    output busy
  );

endinterface

// File: rtl/rc_step_calc.sv
// Combinational RC step toward a selectable target with the minimum-step rule.
module rc_step_calc
  import discrete_pkg::*;
(
  input  sample_t           cur,
  input  sample_t           tgt,
  input  logic [COEF_W-1:0] coef,
  output sample_t           nxt_c
);

  // Next sample value one step closer to the target.
  always_comb begin
    nxt_c = rc_step(cur, tgt, coef);
  end

endmodule

// File: rtl/rc_envelope_cv.sv
// Charge / hold / discharge RC envelope used as the control voltage of the 555 VCO.
module rc_envelope_cv
  import discrete_pkg::*;
#(
  parameter int unsigned       CLOCK_RATE     = 1000000,
  parameter sample_t           V_LOW          = 16'sd0,
  parameter sample_t           V_HIGH         = 16'sd16384,
  parameter logic [COEF_W-1:0] CHARGE_COEF    = 16'd6554,
  parameter logic [COEF_W-1:0] DISCHARGE_COEF = 16'd6554,
  parameter int unsigned       HOLD_SAMPLES   = 64
) (
  input logic               clk,
  input logic               reset,
  rc_envelope_cv_if.slave   env
);

  localparam int unsigned HOLD_W = 16;

  // Reject parameter sets the envelope cannot honour.
  if ((CLOCK_RATE == 32'd0) || (V_HIGH <= V_LOW) || (CHARGE_COEF == '0) ||
      (DISCHARGE_COEF == '0) || (HOLD_SAMPLES > 32'd65535)) begin : g_param_check
    $error("rc_envelope_cv: invalid parameter set");
  end

  env_state_t        state, state_d;
  sample_t           out_q, out_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              pending, pending_d;
  logic              trig_q;

  logic              trig_edge_c;
  logic              eff_c;
  logic              charging_c;
  sample_t           tgt_c;
  logic [COEF_W-1:0] coef_c;
  sample_t           step_nxt_c;

  // Rising-edge detect and the effective trigger seen by a strobe.
  always_comb begin
    trig_edge_c = env.trigger & ~trig_q;
    eff_c       = pending | trig_edge_c;
    charging_c  = eff_c | (state == ENV_CHARGE);
  end

  // One shared step unit; target and coefficient follow the active path.
  always_comb begin
    tgt_c  = V_LOW;
    coef_c = DISCHARGE_COEF;
    if (charging_c) begin
      tgt_c  = V_HIGH;
      coef_c = CHARGE_COEF;
    end
  end

  rc_step_calc u_step (
    .cur   (out_q),
    .tgt   (tgt_c),
    .coef  (coef_c),
    .nxt_c (step_nxt_c)
  );

  // Next-state and next-output logic; everything advances only on the sample strobe.
  always_comb begin
    state_d   = state;
    out_d     = out_q;
    hold_d    = hold_cnt;
    pending_d = pending | trig_edge_c;
    if (env.audio_clk_en) begin
      pending_d = 1'b0;
      if (charging_c) begin
        out_d   = step_nxt_c;
        state_d = ENV_CHARGE;
        if (step_nxt_c == V_HIGH) begin
          if (HOLD_SAMPLES == 0) begin
            state_d = ENV_DISCHARGE;
          end else begin
            state_d = ENV_HOLD;
            hold_d  = HOLD_W'(HOLD_SAMPLES);
          end
        end
      end else begin
        unique case (state)
          ENV_IDLE: begin
            out_d = V_LOW;
          end
          ENV_HOLD: begin
            out_d  = V_HIGH;
            hold_d = hold_cnt - HOLD_W'(1);
            if (hold_cnt <= HOLD_W'(1)) begin
              hold_d  = '0;
              state_d = ENV_DISCHARGE;
            end
          end
          ENV_DISCHARGE: begin
            out_d = step_nxt_c;
            if (step_nxt_c == V_LOW) begin
              state_d = ENV_IDLE;
            end
          end
          default: begin
            state_d = ENV_IDLE;
          end
        endcase
      end
    end
  end

  // State, output and trigger-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ENV_IDLE;
      out_q    <= V_LOW;
      hold_cnt <= '0;
      pending  <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state    <= state_d;
      out_q    <= out_d;
      hold_cnt <= hold_d;
      pending  <= pending_d;
      trig_q   <= env.trigger;
    end
  end

  assign env.out  = out_q;
  assign env.busy = (state != ENV_IDLE);

endmodule

// File: tb/tb_rc_envelope_cv.sv
// Directed bench for rc_envelope_cv: default build (A) and a zero-hold build (B).
module tb_rc_envelope_cv;
  import discrete_pkg::*;

  localparam int COEF = 6554;
  localparam int VHI  = 16384;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic trig_a;
  logic trig_b;

  int n_total = 0;
  int n_bad   = 0;
  int m;

  always #5 clk = ~clk;

  rc_envelope_cv_if ifa ();
  rc_envelope_cv_if ifb ();

  assign ifa.audio_clk_en = en;
  assign ifa.trigger      = trig_a;
  assign ifb.audio_clk_en = en;
  assign ifb.trigger      = trig_b;

  rc_envelope_cv u_dut_a (
    .clk   (clk),
    .reset (reset),
    .env   (ifa)
  );

  rc_envelope_cv #(.HOLD_SAMPLES(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .env   (ifb)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference step: integer floor division, minimum step of one LSB.
  function automatic int model_step(input int cur, input int tgt);
    int d, p, s;
    d = tgt - cur;
    p = d * COEF;
    if (p >= 0) s = p / 65536;
    else        s = -((-p + 65535) / 65536);
    if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
    return cur + s;
  endfunction

  function automatic int rd_out(input bit b);
    return b ? int'(ifb.out) : int'(ifa.out);
  endfunction

  function automatic int rd_busy(input bit b);
    return b ? int'(ifb.busy) : int'(ifa.busy);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period();
    tick(19);
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic step_once(input bit b, input int tgt, inout int mv);
    period();
    mv = model_step(mv, tgt);
    check(b ? "step_b" : "step_a", rd_out(b), mv);
  endtask

  task automatic reach(input bit b, input int tgt, inout int mv);
    int guard = 0;
    while (mv != tgt && guard < 400) begin
      step_once(b, tgt, mv);
      guard++;
    end
    check(b ? "reach_b" : "reach_a", rd_out(b), tgt);
  endtask

  task automatic hold_run(input int n);
    for (int i = 0; i < n; i++) begin
      period();
      check("hold_out", rd_out(0), VHI);
      check("hold_busy", rd_busy(0), 1);
    end
  endtask

  // Pulse trigger A one clock wide, 5 clocks after the last strobe, then run to the next strobe.
  task automatic pulse_then_strobe();
    tick(4);
    trig_a = 1'b1;
    tick(1);
    trig_a = 1'b0;
    tick(14);
    check("pulse_wait", rd_out(0), m);
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    en     = 1'b0;
    trig_a = 1'b0;
    trig_b = 1'b0;
    reset  = 1'b1;
    tick(3);
    check("rst_out_a", rd_out(0), 0);
    check("rst_busy_a", rd_busy(0), 0);
    check("rst_out_b", rd_out(1), 0);
    reset = 1'b0;
    tick(2);
    period();
    check("idle_out", rd_out(0), 0);
    check("idle_busy", rd_busy(0), 0);

    // Charge with trigger held high; no restart through the whole envelope.
    trig_a = 1'b1;
    period();
    check("chg1", rd_out(0), 1638);
    check("chg1_busy", rd_busy(0), 1);
    period();
    check("chg2", rd_out(0), 3112);
    m = 3112;
    reach(0, VHI, m);
    hold_run(32);
    trig_a = 1'b0;
    hold_run(32);
    period();
    check("dis1", rd_out(0), 14745);
    m = 14745;
    reach(0, 0, m);
    check("idle_after_dis", rd_busy(0), 0);

    // Short pulse between strobes starts the next charge.
    m = 0;
    pulse_then_strobe();
    check("pulse_chg1", rd_out(0), 1638);
    m = 1638;
    reach(0, VHI, m);
    hold_run(64);
    period();
    check("dis1_b", rd_out(0), 14745);
    m = 14745;
    while (m >= 9000) step_once(0, 0, m);

    // Retrigger mid-discharge continues from the current value, then a full hold.
    pulse_then_strobe();
    m = model_step(m, VHI);
    check("retrig", rd_out(0), m);
    check("retrig_busy", rd_busy(0), 1);
    reach(0, VHI, m);
    hold_run(64);
    period();
    check("dis1_c", rd_out(0), 14745);
    m = 14745;
    reach(0, 0, m);
    check("idle_busy2", rd_busy(0), 0);

    // Edge coincident with the strobe charges in that same sample.
    tick(19);
    en     = 1'b1;
    trig_a = 1'b1;
    tick(1);
    en     = 1'b0;
    check("coinc", rd_out(0), 1638);
    trig_a = 1'b0;
    period();
    check("coinc2", rd_out(0), 3112);

    // Async reset mid-charge with an edge pending: immediate clear, pending dropped.
    tick(3);
    trig_a = 1'b1;
    tick(1);
    trig_a = 1'b0;
    tick(2);
    #3;
    reset = 1'b1;
    #1;
    check("rst_mid_out", rd_out(0), 0);
    check("rst_mid_busy", rd_busy(0), 0);
    tick(2);
    reset = 1'b0;
    period();
    check("rst_post_out", rd_out(0), 0);
    check("rst_post_busy", rd_busy(0), 0);
    period();
    check("rst_post_out2", rd_out(0), 0);

    // Zero-hold build: coincident start, then straight from V_HIGH into discharge.
    tick(19);
    en     = 1'b1;
    trig_b = 1'b1;
    tick(1);
    en     = 1'b0;
    check("b_chg1", rd_out(1), 1638);
    trig_b = 1'b0;
    m = 1638;
    reach(1, VHI, m);
    check("b_busy_top", rd_busy(1), 1);
    period();
    check("b_nohold", rd_out(1), 14745);
    m = 14745;
    reach(1, 0, m);
    check("b_idle", rd_busy(1), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
